// File: rtl/wb_pkg.sv
// Shared constants and types for the register write-back arbiter and scoreboard.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Producer handshakes, decode claim port and register-file write port of reg_writeback.
interface reg_writeback_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic              alloc_valid;
    logic [ADDR_W-1:0] alloc_addr;
    logic              alloc_ready;

    logic              write_enable1;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [NREG-1:0]   busy;
    logic              wb_err;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  alloc_valid, alloc_addr,
        output alu_ready, ld_ready, alloc_ready,
        output write_enable1, write_addr, write_data, busy, wb_err
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output alloc_valid, alloc_addr,
        input  alu_ready, ld_ready, alloc_ready,
        input  write_enable1, write_addr, write_data, busy, wb_err
    );

endinterface

// File: rtl/wb_slot.sv
// One-entry holding register for a producer result; frees itself when drained and
// can be refilled at the same edge.
module wb_slot
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output slot_t             slot
);

    slot_t slot_q, slot_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        in_ready = !slot_q.valid || drain;
        slot_d   = slot_q;
        if (in_valid && in_ready) begin
            slot_d.valid = 1'b1;
            slot_d.addr  = in_addr;
            slot_d.data  = in_data;
        end else if (drain) begin
            slot_d.valid = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/reg_writeback.sv
// Write-back arbiter: serialises ALU and load results onto the register-file write port
// and keeps the per-register outstanding-producer scoreboard.
module reg_writeback
    import wb_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    reg_writeback_if.slave bus
);

    slot_t alu_slot, ld_slot, gnt;
    logic  alu_drain, ld_drain, alloc_fire;

    src_e              last_q, last_d;
    logic              write_enable1_q, write_enable1_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wb_err_q, wb_err_d;

    wb_slot u_alu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.alu_valid),
        .in_ready (bus.alu_ready),
        .in_addr  (bus.alu_addr),
        .in_data  (bus.alu_data),
        .drain    (alu_drain),
        .slot     (alu_slot)
    );

    wb_slot u_ld_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.ld_valid),
        .in_ready (bus.ld_ready),
        .in_addr  (bus.ld_addr),
        .in_data  (bus.ld_data),
        .drain    (ld_drain),
        .slot     (ld_slot)
    );

    // ALU wins when alone or when the load unit had the previous grant.
    always_comb begin
        alu_drain = alu_slot.valid && (!ld_slot.valid || last_q == SRC_LD);
        ld_drain  = ld_slot.valid && !alu_drain;
        gnt       = alu_drain ? alu_slot : ld_slot;
    end

    assign bus.alloc_ready = !busy_q[bus.alloc_addr];
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

    always_comb begin
        last_d          = last_q;
        write_enable1_d = 1'b0;
        write_addr_d    = write_addr_q;
        write_data_d    = write_data_q;
        busy_d          = busy_q;
        wb_err_d        = wb_err_q;
        if (gnt.valid) begin
            write_enable1_d   = 1'b1;
            write_addr_d      = gnt.addr;
            write_data_d      = gnt.data;
            busy_d[gnt.addr]  = 1'b0;
            last_d            = alu_drain ? SRC_ALU : SRC_LD;
            if (!busy_q[gnt.addr]) begin
                wb_err_d = 1'b1;
            end
        end
        // Applied after the clear: a freshly claimed register belongs to the new producer.
        if (alloc_fire) begin
            busy_d[bus.alloc_addr] = 1'b1;
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared by reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q          <= SRC_LD;
            write_enable1_q <= 1'b0;
            write_addr_q    <= '0;
            write_data_q    <= '0;
            busy_q          <= '0;
            wb_err_q        <= 1'b0;
        end else begin
            last_q          <= last_d;
            write_enable1_q <= write_enable1_d;
            write_addr_q    <= write_addr_d;
            write_data_q    <= write_data_d;
            busy_q          <= busy_d;
            wb_err_q        <= wb_err_d;
        end
    end

    assign bus.write_enable1 = write_enable1_q;
    assign bus.write_addr    = write_addr_q;
    assign bus.write_data    = write_data_q;
    assign bus.busy          = busy_q;
    assign bus.wb_err        = wb_err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reg_writeback;
    import wb_pkg::*;

    logic clk;
    logic rst_n;
    reg_writeback_if bus ();

    reg_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending results per producer, scoreboard bits, expected write port.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              pend_alu[$];
    ent_t              pend_ld[$];
    bit   [NREG-1:0]   m_busy;
    bit                m_err;
    bit                m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    bit                m_last_alu;

    task automatic model_reset();
        pend_alu.delete();
        pend_ld.delete();
        m_busy     = '0;
        m_err      = 1'b0;
        m_we       = 1'b0;
        m_waddr    = '0;
        m_wdata    = '0;
        m_last_alu = 1'b0;
    endtask

    // 0 = nobody, 1 = ALU, 2 = load
    function automatic int pick();
        if (pend_alu.size() > 0 && pend_ld.size() > 0) return m_last_alu ? 2 : 1;
        if (pend_alu.size() > 0) return 1;
        if (pend_ld.size() > 0)  return 2;
        return 0;
    endfunction

    function automatic bit exp_alu_ready();
        return pend_alu.size() == 0 || pick() == 1;
    endfunction

    function automatic bit exp_ld_ready();
        return pend_ld.size() == 0 || pick() == 2;
    endfunction

    task automatic model_step();
        int            p;
        ent_t          e;
        bit [NREG-1:0] old_busy;
        bit            a_rdy, l_rdy;
        p        = pick();
        a_rdy    = exp_alu_ready();
        l_rdy    = exp_ld_ready();
        old_busy = m_busy;
        m_we     = 1'b0;
        if (p != 0) begin
            if (p == 1) e = pend_alu.pop_front();
            else        e = pend_ld.pop_front();
            m_we           = 1'b1;
            m_waddr        = e.addr;
            m_wdata        = e.data;
            m_busy[e.addr] = 1'b0;
            m_last_alu     = (p == 1);
            if (!old_busy[e.addr]) m_err = 1'b1;
        end
        if (bus.alu_valid && a_rdy) pend_alu.push_back('{bus.alu_addr, bus.alu_data});
        if (bus.ld_valid && l_rdy)  pend_ld.push_back('{bus.ld_addr, bus.ld_data});
        if (bus.alloc_valid && !old_busy[bus.alloc_addr]) m_busy[bus.alloc_addr] = 1'b1;
    endtask

    // Every clock advance goes through here, so model and DUT see the same edges.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("alu_ready",     bus.alu_ready,     exp_alu_ready());
            check("ld_ready",      bus.ld_ready,      exp_ld_ready());
            check("alloc_ready",   bus.alloc_ready,   !m_busy[bus.alloc_addr]);
            check("write_enable1", bus.write_enable1, m_we);
            check("write_addr",    bus.write_addr,    m_waddr);
            check("write_data",    bus.write_data,    m_wdata);
            check("busy",          bus.busy,          m_busy);
            check("wb_err",        bus.wb_err,        m_err);
        end
    end

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_addr    = '0;
        bus.alu_data    = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.alloc_valid = 1'b0;
        bus.alloc_addr  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input int r);
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = ADDR_W'(r);
        cycle();
        bus.alloc_valid = 1'b0;
    endtask

    int          seq_addr[$];
    int          seq_cyc[$];
    int          ia, il;
    bit          a_ok, l_ok;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("rst_we",    bus.write_enable1, 1'b0);
        check("rst_busy",  bus.busy,          16'h0000);
        repeat (2) cycle();
        rst_n = 1'b1;
        #1;
        check("rst_waddr",     bus.write_addr, 4'h0);
        check("rst_wdata",     bus.write_data, 32'h0);
        check("rst_err",       bus.wb_err,     1'b0);
        check("rst_alu_ready", bus.alu_ready,  1'b1);
        check("rst_ld_ready",  bus.ld_ready,   1'b1);

        // Single ALU write of r3: two edges from handshake to strobe.
        alloc(3);
        check("t1_busy_set", bus.busy, 16'h0008);
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd3;
        bus.alu_data  = 32'h0000_00AA;
        #1;
        check("t1_alu_ready", bus.alu_ready, 1'b1);
        cycle();
        bus.alu_valid = 1'b0;
        check("t1_we_k", bus.write_enable1, 1'b0);
        cycle();
        check("t1_we_k1", bus.write_enable1, 1'b1);
        check("t1_addr",  bus.write_addr,    4'd3);
        check("t1_data",  bus.write_data,    32'h0000_00AA);
        check("t1_busy3", bus.busy[3],       1'b0);

        // Simultaneous ALU r1 and LD r2 from reset: ALU first, LD one cycle later.
        do_reset();
        alloc(1);
        alloc(2);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = 32'h11;
        bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd2; bus.ld_data  = 32'h22;
        cycle();
        idle_inputs();
        check("t2_ld_ready_low", bus.ld_ready,      1'b0);
        check("t2_alu_ready",    bus.alu_ready,     1'b1);
        check("t2_we_k",         bus.write_enable1, 1'b0);
        cycle();
        check("t2_we1",   bus.write_enable1, 1'b1);
        check("t2_addr1", bus.write_addr,    4'd1);
        check("t2_data1", bus.write_data,    32'h11);
        check("t2_ld_ready_back", bus.ld_ready, 1'b1);
        cycle();
        check("t2_we2",   bus.write_enable1, 1'b1);
        check("t2_addr2", bus.write_addr,    4'd2);
        check("t2_data2", bus.write_data,    32'h22);
        cycle();
        check("t2_idle", bus.write_enable1, 1'b0);

        // Both producers streaming three results each: strict alternation, one per cycle.
        for (int r = 8; r < 14; r++) alloc(r);
        ia = 0;
        il = 0;
        for (int c = 0; c < 12; c++) begin
            bus.alu_valid = (ia < 3);
            bus.alu_addr  = ADDR_W'(8 + 2 * ia);
            bus.alu_data  = 32'hA0 + ia;
            bus.ld_valid  = (il < 3);
            bus.ld_addr   = ADDR_W'(9 + 2 * il);
            bus.ld_data   = 32'hB0 + il;
            #1;
            a_ok = bus.alu_valid && bus.alu_ready;
            l_ok = bus.ld_valid && bus.ld_ready;
            cycle();
            if (a_ok) ia++;
            if (l_ok) il++;
            if (bus.write_enable1) begin
                seq_addr.push_back(int'(bus.write_addr));
                seq_cyc.push_back(c);
            end
        end
        idle_inputs();
        check("t3_count", seq_addr.size(), 6);
        for (int i = 0; i < 6 && i < seq_addr.size(); i++) begin
            check("t3_order",   seq_addr[i], 8 + i);
            check("t3_b2b",     seq_cyc[i],  seq_cyc[0] + i);
        end
        check("t3_busy_clear", bus.busy, 16'h0000);

        // Write to idle r5 retires at the same edge r5 is claimed again: the claim wins.
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 32'h55;
        cycle();
        bus.alu_valid   = 1'b0;
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 4'd5;
        #1;
        check("t4_alloc_ok", bus.alloc_ready, 1'b1);
        cycle();
        bus.alloc_valid = 1'b0;
        check("t4_we",    bus.write_enable1, 1'b1);
        check("t4_addr",  bus.write_addr,    4'd5);
        check("t4_busy5", bus.busy[5],       1'b1);
        check("t4_err",   bus.wb_err,        1'b1);
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 4'd5;
        #1;
        check("t4_alloc_blocked", bus.alloc_ready, 1'b0);
        cycle();
        bus.alloc_valid = 1'b0;
        check("t4_busy5_hold", bus.busy[5], 1'b1);

        // Load to unclaimed r7: written anyway, error sticks.
        do_reset();
        check("t5_err_clr", bus.wb_err, 1'b0);
        bus.ld_valid = 1'b1; bus.ld_addr = 4'd7; bus.ld_data = 32'h77;
        cycle();
        bus.ld_valid = 1'b0;
        cycle();
        check("t5_we",   bus.write_enable1, 1'b1);
        check("t5_addr", bus.write_addr,    4'd7);
        check("t5_data", bus.write_data,    32'h77);
        check("t5_err",  bus.wb_err,        1'b1);
        repeat (10) cycle();
        check("t5_err_sticky", bus.wb_err,        1'b1);
        check("t5_idle",       bus.write_enable1, 1'b0);

        // Reset with both slots full and r4..r7 claimed.
        do_reset();
        for (int r = 4; r < 8; r++) alloc(r);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd4; bus.alu_data = 32'h44;
        bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd5; bus.ld_data  = 32'h55;
        cycle();
        idle_inputs();
        check("t6_busy_pre",  bus.busy,     16'h00F0);
        check("t6_both_full", bus.ld_ready, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_we0",    bus.write_enable1, 1'b0);
        check("t6_addr0",  bus.write_addr,    4'd0);
        check("t6_data0",  bus.write_data,    32'h0);
        check("t6_busy0",  bus.busy,          16'h0000);
        check("t6_err0",   bus.wb_err,        1'b0);
        check("t6_alu_rdy", bus.alu_ready,    1'b1);
        check("t6_ld_rdy",  bus.ld_ready,     1'b1);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t6_no_stale", bus.write_enable1, 1'b0);
        end

        // Random traffic against the model; ALU targets even, load odd registers.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.alloc_valid = ($urandom_range(0, 2) == 0);
            bus.alloc_addr  = ADDR_W'($urandom_range(0, NREG - 1));
            bus.alu_valid   = ($urandom_range(0, 3) != 0);
            bus.alu_addr    = ADDR_W'(2 * $urandom_range(0, NREG / 2 - 1));
            bus.alu_data    = $urandom;
            bus.ld_valid    = ($urandom_range(0, 2) != 0);
            bus.ld_addr     = ADDR_W'(2 * $urandom_range(0, NREG / 2 - 1) + 1);
            bus.ld_data     = $urandom;
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back arbiter and register scoreboard in front of the CPU's 16 x 32-bit register file write port. It accepts results from two producers (ALU and load unit) over valid/ready handshakes and buffers one result per producer. It serialises them onto the single register-file write port, one write per cycle. It also tracks which registers have an outstanding producer, so decode can stall on read-after-write hazards.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 4, register address width
- NREG, 16, number of registers (2**ADDR_W)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU slot can accept
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load slot can accept
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- alloc_valid  in  1  decode claims a destination register
- alloc_addr  in  ADDR_W  register being claimed
- alloc_ready  out  1  claim accepted (combinational: !busy[alloc_addr])
- write_enable1  out  1  register-file write strobe, registered
- write_addr  out  ADDR_W  register-file write address, registered
- write_data  out  DATA_W  register-file write data, registered
- busy  out  NREG  per-register outstanding-producer mask, registered
- wb_err  out  1  sticky: a write arrived for a register that was not busy

## Operation
- Each source has a 1-entry slot (valid, addr, data).
- ready = slot empty OR slot granted this cycle, so a source can sustain one transfer per cycle when it is not contended.
- A transfer happens at an edge where valid && ready; the slot captures addr/data.
- Grant: if exactly one slot is full, that slot wins. If both are full, round-robin on a last-grant flag; after reset the flag favours ALU.
- Granted slot at edge E: write_addr/write_data take the slot contents, write_enable1 <= 1, and the slot empties unless refilled at the same edge.
- If no slot is full: write_enable1 <= 0. write_addr and write_data hold their values.
- Scoreboard set: busy[alloc_addr] <= 1 on alloc_valid && alloc_ready.
- Scoreboard clear: busy[write addr] <= 0 at the grant edge.
- Set and clear of the same register at the same edge: set wins, because a new producer now owns the register.
- Grant to a register with busy = 0: the write still happens and wb_err <= 1. wb_err clears only on reset.
- Two slots holding the same address is a protocol violation that the scoreboard prevents. Ordering between them is not guaranteed.

## Timing
- Reset (rst_n low, async): slots empty, busy = 0, write_enable1 = 0, write_addr = 0, write_data = 0, wb_err = 0, last-grant = LD (so ALU wins first).
- alu_ready = ld_ready = 1 out of reset. Reset mid-operation drops any buffered results.
- Latency: handshake at edge k, grant at edge k+1, write_enable1 high for the cycle after k+1. That is two edges, if uncontended.
- Contended: the loser is granted one edge later and its ready stays low meanwhile.
- busy drops in the same cycle write_enable1 is high. The register file writes combinationally, so a reader that sees busy = 0 gets the new value.
- Throughput: one register write per cycle maximum. Back-to-back grants from alternating sources are legal.

## Structure
- Package wb_pkg holds:
  - DATA_W, ADDR_W, NREG constants
  - src_e enum {SRC_ALU, SRC_LD} for the grant/last-grant flag
  - slot struct {valid, addr, data}
- Sub-module wb_slot is a 1-entry holding register with a valid/ready handshake and a drain input, instantiated twice.
- The top module holds the arbiter, output register and scoreboard.

## Test plan
- Reset, then alloc r3, ALU sends r3 = 0x0000_00AA -> alu_ready = 1; two edges later write_enable1 = 1, write_addr = 3, write_data = 0xAA; busy[3] falls in that cycle.
- Alloc r1 and r2; ALU sends r1 = 0x11 and LD sends r2 = 0x22 at the same edge -> r1 is written first, then r2 on the next cycle; ld_ready is 0 for one cycle.
- Both sources continuously valid for 6 results -> write_addr strictly alternates ALU/LD, one write every cycle, no drops.
- Alloc r5 at the same edge r5's previous write is granted -> busy[5] stays 1; a second alloc of r5 gets alloc_ready = 0.
- LD writes r7 with busy[7] = 0 -> r7 is written and wb_err = 1, still 1 after 10 idle cycles.
- Drop rst_n with both slots full and busy = 0x00F0 -> all outputs 0 immediately; after release, no stale write appears.
